// File: rtl/rps_pkg.sv
// rps_pkg: move/result/state encodings and the round-winner rule for the RPS match sequencer
package rps_pkg;
  typedef enum logic [1:0] {MV_NONE = 2'b00, MV_ROCK = 2'b01, MV_PAPER = 2'b10, MV_SCISSORS = 2'b11} move_t;
  typedef enum logic [1:0] {RES_DRAW = 2'b00, RES_P1 = 2'b01, RES_P2 = 2'b10} result_t;
  typedef enum logic [2:0] {ST_IDLE, ST_COUNT, ST_CAPTURE, ST_REVEAL, ST_SCORE, ST_DONE} state_t;
  function automatic result_t rps_winner(input move_t a, input move_t b);
    return (a == b) ? RES_DRAW :
           (a == MV_NONE) ? RES_P2 :
           (b == MV_NONE) ? RES_P1 :
           ((a == MV_ROCK && b == MV_SCISSORS) || (a == MV_SCISSORS && b == MV_PAPER) ||
            (a == MV_PAPER && b == MV_ROCK)) ? RES_P1 : RES_P2;
  endfunction
endpackage

// File: rtl/rps_tick_prescaler.sv
// rps_tick_prescaler: one-cycle tick every TICK_DIV clocks; ports clk, reset (sync, active-high), clr (restart count), tick
module rps_tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV + 1);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] r_cnt;
  assign tick = (r_cnt == LAST);
  always_ff @(posedge clk) r_cnt <= (reset || clr || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/rps_round_sequencer.sv
// rps_round_sequencer: RPS match FSM (countdown/capture/reveal/score) driving phase, tick_cnt, capture_en, result, result_vld, scores, match_done from start/abort/player moves; define RPS_SEQ_TIE_REPLAY_EN to replay drawn rounds
module rps_round_sequencer
  import rps_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int COUNT_TICKS   = 3,
  parameter int CAPTURE_TICKS = 2,
  parameter int REVEAL_TICKS  = 2,
  parameter int MAX_ROUNDS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  output logic [2:0] phase,
  output logic [3:0] tick_cnt,
  output logic       capture_en,
  output logic [1:0] result,
  output logic       result_vld,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       match_done
);
  localparam logic [3:0] MAJ = 4'((MAX_ROUNDS + 1) / 2);
  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS);
  state_t r_state, w_next;
  move_t r_p1, r_p2;
  result_t r_result, w_res;
  logic w_tick, w_enter, w_round_inc;
  logic [3:0] r_tick_cnt, w_load, r_p1_score, r_p2_score, r_rounds;
  rps_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .reset(reset),
    .clr  (abort || w_enter),
    .tick (w_tick)
  );
  assign w_enter = (w_next != r_state);
  assign w_res = rps_winner(r_p1, r_p2);
`ifdef RPS_SEQ_TIE_REPLAY_EN
  assign w_round_inc = (w_res != RES_DRAW);
`else
  assign w_round_inc = 1'b1;
`endif
  assign w_load = (w_next == ST_COUNT)   ? 4'(COUNT_TICKS - 1) :
                  (w_next == ST_CAPTURE) ? 4'(CAPTURE_TICKS - 1) :
                  (w_next == ST_REVEAL)  ? 4'(REVEAL_TICKS - 1) : 4'd0;
  always_ff @(posedge clk) r_state <= reset ? ST_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (abort) w_next = ST_IDLE;
    else
      case (r_state)
        ST_IDLE, ST_DONE: w_next = start ? ST_COUNT : r_state;
        ST_COUNT:   w_next = (w_tick && r_tick_cnt == '0) ? ST_CAPTURE : r_state;
        ST_CAPTURE: w_next = (w_tick && r_tick_cnt == '0) ? ST_REVEAL : r_state;
        ST_REVEAL:  w_next = (w_tick && r_tick_cnt == '0) ? ST_SCORE : r_state;
        ST_SCORE:   w_next = (r_p1_score == MAJ || r_p2_score == MAJ || r_rounds == LAST_ROUND) ? ST_DONE : ST_COUNT;
        default:    w_next = ST_IDLE;
      endcase
  end
  // Round result and scores are committed on SCORE entry so they are already valid during the SCORE cycle.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_tick_cnt <= '0;
      r_p1       <= MV_NONE;
      r_p2       <= MV_NONE;
      r_result   <= RES_DRAW;
      r_p1_score <= '0;
      r_p2_score <= '0;
      r_rounds   <= '0;
    end else begin
      if (w_enter) r_tick_cnt <= w_load;
      else if (w_tick && r_tick_cnt != '0) r_tick_cnt <= r_tick_cnt - 1'b1;
      if (w_enter && w_next == ST_COUNT) begin
        r_p1 <= MV_NONE;
        r_p2 <= MV_NONE;
      end
      if (r_state == ST_CAPTURE && p1_valid && p1_move != 2'b00 && r_p1 == MV_NONE) r_p1 <= move_t'(p1_move);
      if (r_state == ST_CAPTURE && p2_valid && p2_move != 2'b00 && r_p2 == MV_NONE) r_p2 <= move_t'(p2_move);
      if (w_enter && w_next == ST_COUNT && r_state != ST_SCORE) begin
        r_p1_score <= '0;
        r_p2_score <= '0;
        r_rounds   <= '0;
      end
      if (w_enter && w_next == ST_SCORE) begin
        r_result <= w_res;
        if (w_res == RES_P1 && r_p1_score != 4'hF) r_p1_score <= r_p1_score + 1'b1;
        if (w_res == RES_P2 && r_p2_score != 4'hF) r_p2_score <= r_p2_score + 1'b1;
        if (w_round_inc && r_rounds != 4'hF) r_rounds <= r_rounds + 1'b1;
      end
    end
  end
  assign phase      = r_state;
  assign tick_cnt   = r_tick_cnt;
  assign capture_en = (r_state == ST_CAPTURE);
  assign result     = r_result;
  assign result_vld = (r_state == ST_SCORE);
  assign p1_score   = r_p1_score;
  assign p2_score   = r_p2_score;
  assign match_done = (r_state == ST_DONE);
endmodule

// File: tb/tb_rps_round_sequencer.sv
// tb_rps_round_sequencer: directed self-checking bench for rps_round_sequencer with TICK_DIV=4, 3/2/2 ticks, 3 rounds
module tb_rps_round_sequencer;
`ifdef RPS_SEQ_TIE_REPLAY_EN
  localparam int TIE = 1;
`else
  localparam int TIE = 0;
`endif
  logic clk, reset, start, abort, p1_valid, p2_valid;
  logic [1:0] p1_move, p2_move, result;
  logic [2:0] phase;
  logic [3:0] tick_cnt, p1_score, p2_score;
  logic capture_en, result_vld, match_done;
  int n_checks = 0;
  int n_fail = 0;
  rps_round_sequencer #(
    .TICK_DIV(4), .COUNT_TICKS(3), .CAPTURE_TICKS(2), .REVEAL_TICKS(2), .MAX_ROUNDS(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .p1_move(p1_move), .p1_valid(p1_valid), .p2_move(p2_move), .p2_valid(p2_valid),
    .phase(phase), .tick_cnt(tick_cnt), .capture_en(capture_en), .result(result),
    .result_vld(result_vld), .p1_score(p1_score), .p2_score(p2_score), .match_done(match_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic [1:0] m1, input logic [1:0] m2, input logic v);
    p1_move = m1;
    p2_move = m2;
    p1_valid = v;
    p2_valid = v;
  endtask
  // Entered at the first COUNT cycle of a round; returns in its SCORE cycle.
  task automatic play_round(input string tag, input logic [1:0] a1, input logic [1:0] b1,
                            input logic [1:0] a2, input logic [1:0] b2);
    check({tag, "_cnt_phase"}, phase, 1);
    check({tag, "_cnt_load"}, tick_cnt, 2);
    drive(2'b11, 2'b01, 1'b1);
    tick(1);
    drive(2'b00, 2'b00, 1'b0);
    tick(10);
    check({tag, "_cnt_end_phase"}, phase, 1);
    check({tag, "_cnt_end_ticks"}, tick_cnt, 0);
    tick(1);
    check({tag, "_cap_phase"}, phase, 2);
    check({tag, "_cap_en"}, capture_en, 1);
    check({tag, "_cap_load"}, tick_cnt, 1);
    drive(a1, a2, 1'b1);
    tick(1);
    drive(b1, b2, 1'b1);
    tick(1);
    drive(2'b00, 2'b00, 1'b0);
    tick(5);
    check({tag, "_cap_end"}, phase, 2);
    tick(1);
    check({tag, "_rev_phase"}, phase, 3);
    check({tag, "_rev_cap_en"}, capture_en, 0);
    check({tag, "_rev_load"}, tick_cnt, 1);
    tick(7);
    check({tag, "_rev_end"}, phase, 3);
    check({tag, "_rev_vld"}, result_vld, 0);
    tick(1);
    check({tag, "_score_phase"}, phase, 4);
    check({tag, "_score_vld"}, result_vld, 1);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    drive(2'b00, 2'b00, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_phase", phase, 0);
    check("rst_ticks", tick_cnt, 0);
    check("rst_result", result, 0);
    check("rst_vld", result_vld, 0);
    check("rst_scores", {p1_score, p2_score}, 0);
    check("rst_done", match_done, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    play_round("a1", 2'b01, 2'b00, 2'b11, 2'b00);
    check("a1_result", result, 1);
    check("a1_p1", p1_score, 1);
    check("a1_p2", p2_score, 0);
    tick(1);
    check("a1_next", phase, 1);
    check("a1_hold", result, 1);
    check("a1_vld_off", result_vld, 0);
    play_round("a2", 2'b10, 2'b00, 2'b01, 2'b00);
    check("a2_result", result, 1);
    check("a2_p1", p1_score, 2);
    tick(1);
    check("a2_done_phase", phase, 5);
    check("a2_done", match_done, 1);
    check("a2_p2", p2_score, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("b_restart_scores", {p1_score, p2_score}, 0);
    check("b_restart_done", match_done, 0);
    play_round("b1", 2'b00, 2'b00, 2'b00, 2'b10);
    check("b1_result", result, 2);
    check("b1_p1", p1_score, 0);
    check("b1_p2", p2_score, 1);
    tick(1);
    check("b1_next", phase, 1);
    play_round("b2", 2'b00, 2'b00, 2'b00, 2'b00);
    check("b2_result", result, 0);
    check("b2_p2", p2_score, 1);
    tick(1);
    check("b2_next", phase, 1);
    play_round("b3", 2'b10, 2'b01, 2'b01, 2'b10);
    check("b3_result", result, 1);
    check("b3_p1", p1_score, 1);
    check("b3_p2", p2_score, 1);
    tick(1);
    check("b3_next", phase, TIE ? 1 : 5);
    check("b3_done", match_done, TIE ? 0 : 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort1_phase", phase, 0);
    check("abort1_scores", {p1_score, p2_score}, 0);
    check("abort1_result", result, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      play_round($sformatf("c%0d", r), 2'b01, 2'b00, 2'b01, 2'b00);
      check($sformatf("c%0d_result", r), result, 0);
      check($sformatf("c%0d_scores", r), {p1_score, p2_score}, 0);
      tick(1);
      check($sformatf("c%0d_next", r), phase, (r == 2 && TIE == 0) ? 5 : 1);
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort2_phase", phase, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    play_round("d1", 2'b11, 2'b00, 2'b10, 2'b00);
    check("d1_result", result, 1);
    check("d1_p1", p1_score, 1);
    tick(13);
    check("d2_cap", phase, 2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("d2_start_ignored", phase, 2);
    check("d2_start_ticks", tick_cnt, 1);
    tick(7);
    check("d2_rev", phase, 3);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("d2_abort_phase", phase, 0);
    check("d2_abort_p1", p1_score, 0);
    check("d2_abort_result", result, 0);
    check("d2_abort_ticks", tick_cnt, 0);
    check("d2_abort_done", match_done, 0);
    tick(2);
    check("d2_idle_stays", phase, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
